// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// matmul_seq_ctrl: register-mapped sequencer for the matmul datapath (IDLE/LOAD/RUN/DONE).
// Optional RUN watchdog enabled by defining MATMUL_SEQ_TIMEOUT_EN. Rev 1.0
module matmul_seq_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int BUS_WIDTH      = 16,
  parameter int LOAD_CYCLES    = (BUS_WIDTH / DATA_WIDTH) * (BUS_WIDTH / DATA_WIDTH),
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic                 cfg_re_i,
  input  logic [1:0]           cfg_addr_i,
  input  logic [BUS_WIDTH-1:0] cfg_wdata_i,
  output logic [BUS_WIDTH-1:0] cfg_rdata_o,
  output logic                 start_o,
  output logic                 mode_o,
  output logic [1:0]           n_dim_o,
  output logic [1:0]           k_dim_o,
  output logic [1:0]           m_dim_o,
  input  logic                 finish_mul_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] flags_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 host_sp_gnt_o
);

  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int NFLAGS  = MAX_DIM * MAX_DIM;
  localparam int CNT_W   = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [7:0]             ctrl_q, ctrl_d;
  logic                   done_q, done_d;
  logic                   wrerr_q, wrerr_d;
  logic [NFLAGS-1:0]      flags_q, flags_d;
  logic [CNT_W-1:0]       load_cnt_q, load_cnt_d;
  logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
  logic [BUS_WIDTH-1:0]   status_w;
  logic                   timeout_w;
  logic                   ctrl_wr_w, status_wr_w;
  logic                   unused_w;

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic            to_q, to_d;
  logic [TO_W-1:0] run_cnt_q, run_cnt_d;
  assign timeout_w = to_q;
  assign unused_w  = ^cfg_wdata_i[BUS_WIDTH-1:8];
`else
  assign timeout_w = 1'b0;
  assign unused_w  = ^{cfg_wdata_i[BUS_WIDTH-1:8], cfg_wdata_i[3], 1'(TIMEOUT_CYCLES)};
`endif

  assign busy_o        = (state_q == LOAD) || (state_q == RUN);
  assign start_o       = (state_q == RUN);
  assign done_o        = (state_q == DONE);
  assign host_sp_gnt_o = ~busy_o;
  assign mode_o        = ctrl_q[1];
  assign n_dim_o       = ctrl_q[3:2];
  assign k_dim_o       = ctrl_q[5:4];
  assign m_dim_o       = ctrl_q[7:6];
  assign cfg_rdata_o   = rdata_q;

  assign ctrl_wr_w   = cfg_we_i && (cfg_addr_i == 2'd0);
  assign status_wr_w = cfg_we_i && (cfg_addr_i == 2'd1);

  always_comb begin
    status_w              = '0;
    status_w[0]           = busy_o;
    status_w[1]           = done_q;
    status_w[2]           = wrerr_q;
    status_w[3]           = timeout_w;
    status_w[8 +: NFLAGS] = flags_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      done_q     <= 1'b0;
      wrerr_q    <= 1'b0;
      flags_q    <= '0;
      load_cnt_q <= '0;
      rdata_q    <= '0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      to_q       <= 1'b0;
      run_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      done_q     <= done_d;
      wrerr_q    <= wrerr_d;
      flags_q    <= flags_d;
      load_cnt_q <= load_cnt_d;
      rdata_q    <= rdata_d;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      to_q       <= to_d;
      run_cnt_q  <= run_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    done_d     = done_q;
    wrerr_d    = wrerr_q;
    flags_d    = flags_q;
    load_cnt_d = load_cnt_q;
    rdata_d    = rdata_q;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    to_d       = to_q;
    run_cnt_d  = run_cnt_q;
`endif

    // Clears are applied first so any set later in this block wins.
    if (status_wr_w) begin
      if (cfg_wdata_i[1]) done_d  = 1'b0;
      if (cfg_wdata_i[2]) wrerr_d = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
      if (cfg_wdata_i[3]) to_d    = 1'b0;
`endif
    end

    if (ctrl_wr_w) begin
      if (busy_o) wrerr_d = 1'b1;
      else        ctrl_d  = cfg_wdata_i[7:0];
    end

    if (cfg_re_i) begin
      case (cfg_addr_i)
        2'd0:    rdata_d = {{(BUS_WIDTH-8){1'b0}}, ctrl_q};
        2'd1:    rdata_d = status_w;
        default: rdata_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        load_cnt_d = '0;
        if (ctrl_wr_w && cfg_wdata_i[0]) state_d = LOAD;
      end
      LOAD: begin
        if (load_cnt_q == CNT_W'(LOAD_CYCLES - 1)) begin
          load_cnt_d = '0;
          state_d    = RUN;
`ifdef MATMUL_SEQ_TIMEOUT_EN
          run_cnt_d  = '0;
`endif
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (finish_mul_i) begin
          flags_d = flags_i;
          state_d = DONE;
        end
`ifdef MATMUL_SEQ_TIMEOUT_EN
        else if (run_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          flags_d = '0;
          to_d    = 1'b1;
          state_d = DONE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
`endif
      end
      DONE: begin
        // A CTRL write landing here keeps its fields but cannot relaunch.
        ctrl_d[0] = 1'b0;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
`default_nettype none
// tb_matmul_seq_ctrl: directed checks of the matmul sequencer register map and FSM.
module tb_matmul_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic        cfg_re_i = 1'b0;
  logic [1:0]  cfg_addr_i = 2'd0;
  logic [15:0] cfg_wdata_i = 16'h0;
  logic [15:0] cfg_rdata_o;
  logic        start_o, mode_o;
  logic [1:0]  n_dim_o, k_dim_o, m_dim_o;
  logic        finish_mul_i = 1'b0;
  logic [3:0]  flags_i = 4'h0;
  logic        busy_o, done_o, host_sp_gnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  matmul_seq_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_we_i(cfg_we_i), .cfg_re_i(cfg_re_i), .cfg_addr_i(cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
    .start_o(start_o), .mode_o(mode_o),
    .n_dim_o(n_dim_o), .k_dim_o(k_dim_o), .m_dim_o(m_dim_o),
    .finish_mul_i(finish_mul_i), .flags_i(flags_i),
    .busy_o(busy_o), .done_o(done_o), .host_sp_gnt_o(host_sp_gnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk_i);
    cfg_re_i = 1'b1; cfg_addr_i = a;
    @(negedge clk_i);
    cfg_re_i = 1'b0;
    d = cfg_rdata_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] r;
    int n;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_rdata", cfg_rdata_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_gnt", host_sp_gnt_o, 1);
    chk("rst_dims", {mode_o, n_dim_o, k_dim_o, m_dim_o}, 0);
    rst_ni = 1'b1;

    // CTRL without START: fields only, no launch
    wr(2'd0, 16'h00A8);
    chk("dims_a8", {mode_o, n_dim_o, k_dim_o, m_dim_o}, 7'b0_10_10_10);
    chk("idle_busy", busy_o, 0);
    // Same-cycle write and read of CTRL returns the old value
    @(negedge clk_i);
    cfg_we_i = 1'b1; cfg_re_i = 1'b1; cfg_addr_i = 2'd0; cfg_wdata_i = 16'h00F4;
    @(negedge clk_i);
    cfg_we_i = 1'b0; cfg_re_i = 1'b0;
    chk("wr_rd_same", cfg_rdata_o, 16'h00A8);
    rd(2'd0, r);
    chk("ctrl_f4", r, 16'h00F4);
    chk("dims_f4", {mode_o, n_dim_o, k_dim_o, m_dim_o}, 7'b0_01_11_11);

    // Basic operation 0x0055
    wr(2'd0, 16'h0055);
    chk("op1_busy", busy_o, 1);
    chk("op1_gnt", host_sp_gnt_o, 0);
    chk("op1_start_load0", start_o, 0);
    repeat (3) @(negedge clk_i);
    chk("op1_start_load3", start_o, 0);
    @(negedge clk_i);
    chk("op1_start_run", start_o, 1);
    chk("op1_dims", {mode_o, n_dim_o, k_dim_o, m_dim_o}, 7'b0_01_01_01);
    finish_mul_i = 1'b1; flags_i = 4'b0101;
    @(negedge clk_i);
    finish_mul_i = 1'b0;
    chk("op1_done_pulse", done_o, 1);
    chk("op1_done_start", start_o, 0);
    chk("op1_done_busy", busy_o, 0);
    @(negedge clk_i);
    chk("op1_done_low", done_o, 0);
    rd(2'd1, r);
    chk("op1_status", r, 16'h0502);
    rd(2'd0, r);
    chk("op1_ctrl", r, 16'h0054);

    // Reserved addresses and read hold
    rd(2'd3, r);
    chk("rsvd3", r, 0);
    rd(2'd1, r);
    rd(2'd2, r);
    chk("rsvd2", r, 0);
    rd(2'd1, r);
    @(negedge clk_i);
    cfg_addr_i = 2'd3;
    @(negedge clk_i);
    chk("rdata_hold", cfg_rdata_o, 16'h0502);

    // finish_mul_i outside RUN is ignored
    @(negedge clk_i);
    finish_mul_i = 1'b1; flags_i = 4'b1111;
    @(negedge clk_i);
    finish_mul_i = 1'b0;
    chk("idle_fin_done", done_o, 0);
    chk("idle_fin_busy", busy_o, 0);
    rd(2'd1, r);
    chk("idle_fin_status", r, 16'h0502);

    // W1C behaviour of STATUS
    wr(2'd1, 16'h0000);
    rd(2'd1, r);
    chk("w0_keeps", r, 16'h0502);
    wr(2'd1, 16'h000E);
    rd(2'd1, r);
    chk("w1_clears", r, 16'h0500);

    // CTRL write during RUN is rejected
    wr(2'd0, 16'h0057);
    repeat (4) @(negedge clk_i);
    chk("op2_run", start_o, 1);
    chk("op2_mode", mode_o, 1);
    wr(2'd0, 16'h0003);
    chk("op2_mode_kept", mode_o, 1);
    chk("op2_still_run", start_o, 1);
    rd(2'd1, r);
    chk("op2_wrerr", r, 16'h0505);
    rd(2'd0, r);
    chk("op2_ctrl", r, 16'h0057);

    // Reset mid-RUN aborts
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("abort_start", start_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_rdata", cfg_rdata_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("abort_no_done", done_o, 0);
    chk("abort_mode", {mode_o, n_dim_o, k_dim_o, m_dim_o}, 0);
    rd(2'd1, r);
    chk("abort_status", r, 0);
    rd(2'd0, r);
    chk("abort_ctrl", r, 0);

    // DONE set wins over a coincident STATUS clear
    wr(2'd0, 16'h0055);
    repeat (4) @(negedge clk_i);
    finish_mul_i = 1'b1; flags_i = 4'b1010;
    @(negedge clk_i);
    finish_mul_i = 1'b0;
    chk("op3_done", done_o, 1);
    cfg_we_i = 1'b1; cfg_addr_i = 2'd1; cfg_wdata_i = 16'h0002;
    @(negedge clk_i);
    cfg_we_i = 1'b0;
    chk("op3_done_low", done_o, 0);
    rd(2'd1, r);
    chk("op3_set_wins", r, 16'h0A02);

    // RUN watchdog
    wr(2'd1, 16'h000E);
    rd(2'd1, r);
    chk("op4_cleared", r, 16'h0A00);
    wr(2'd0, 16'h0055);
`ifdef MATMUL_SEQ_TIMEOUT_EN
    n = 0;
    while (!done_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    chk("to_latency", n, 259);
    chk("to_done", done_o, 1);
    rd(2'd1, r);
    chk("to_status", r, 16'h000A);
`else
    n = 0;
    repeat (300) @(negedge clk_i);
    chk("noto_busy", busy_o, 1);
    chk("noto_start", start_o, 1);
    rd(2'd1, r);
    chk("noto_status", r, 16'h0A01);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
